// File: rtl/piso_serial_tx.sv
// piso_serial_tx: framed parallel-in/serial-out transmitter (start, DATA_W bits LSB first, stop)
module piso_serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clock,
    input  logic              clearb,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_serial,
    output logic              tx_busy,
    output logic              tx_done
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shifted;
    logic [CW-1:0]     clk_cnt;
    logic [BW-1:0]     bit_cnt;
    logic              last_tick;
    logic              last_bit;

    assign shifted   = shreg >> 1;
    assign last_tick = clk_cnt == CW'(CLKS_PER_BIT - 1);
    assign last_bit  = bit_cnt == BW'(DATA_W - 1);
    assign tx_ready  = state == IDLE;

    // frame sequencer; line, busy and done are registered alongside each state entry
    always_ff @(posedge clock or negedge clearb) begin
        if (!clearb) begin
            state     <= IDLE;
            shreg     <= '0;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            tx_serial <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: if (tx_valid) begin
                    shreg     <= tx_data;
                    state     <= START;
                    tx_serial <= 1'b0;
                    tx_busy   <= 1'b1;
                    clk_cnt   <= '0;
                    bit_cnt   <= '0;
                end
                START: if (last_tick) begin
                    state     <= DATA;
                    clk_cnt   <= '0;
                    bit_cnt   <= '0;
                    tx_serial <= shreg[0];
                end else begin
                    clk_cnt <= clk_cnt + CW'(1);
                end
                DATA: if (last_tick) begin
                    clk_cnt <= '0;
                    if (last_bit) begin
                        state     <= STOP;
                        bit_cnt   <= '0;
                        tx_serial <= 1'b1;
                    end else begin
                        shreg     <= shifted;
                        tx_serial <= shifted[0];
                        bit_cnt   <= bit_cnt + BW'(1);
                    end
                end else begin
                    clk_cnt <= clk_cnt + CW'(1);
                end
                STOP: if (last_tick) begin
                    state   <= IDLE;
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    tx_busy <= 1'b0;
                    tx_done <= 1'b1;
                end else begin
                    clk_cnt <= clk_cnt + CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_piso_serial_tx.sv
// tb_piso_serial_tx: directed self-checking bench for piso_serial_tx
module tb_piso_serial_tx;
    logic       clock  = 1'b0;
    logic       clearb = 1'b0;
    logic [7:0] d0 = '0, d1 = '0;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic       r0, s0, b0, k0;
    logic       r1, s1, b1, k1;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clock = ~clock;

    piso_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u_dut (
        .clock(clock), .clearb(clearb), .tx_data(d0), .tx_valid(v0),
        .tx_ready(r0), .tx_serial(s0), .tx_busy(b0), .tx_done(k0)
    );

    piso_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u_min (
        .clock(clock), .clearb(clearb), .tx_data(d1), .tx_valid(v1),
        .tx_ready(r1), .tx_serial(s1), .tx_busy(b1), .tx_done(k1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic accept(input string tag, input bit sel, input logic [7:0] w, input bit hold);
        @(negedge clock);
        check({tag, " ready"}, sel ? r1 : r0, 1'b1);
        if (sel) begin v1 = 1'b1; d1 = w; end else begin v0 = 1'b1; d0 = w; end
        @(posedge clock);
        #1;
        if (!hold) begin v0 = 1'b0; v1 = 1'b0; end
    endtask

    task automatic expect_frame(input string tag, input bit sel, input logic [7:0] w, input int cpb);
        for (int j = 1; j <= 10 * cpb + 1; j++) begin
            int   idx;
            logic eb;
            @(negedge clock);
            idx = (j - 1) / cpb;
            eb  = (j > 10 * cpb) ? 1'b1 : (idx == 0) ? 1'b0 : (idx <= 8) ? w[idx-1] : 1'b1;
            check($sformatf("%s line c%0d", tag, j),  sel ? s1 : s0, eb);
            check($sformatf("%s busy c%0d", tag, j),  sel ? b1 : b0, j <= 10 * cpb);
            check($sformatf("%s done c%0d", tag, j),  sel ? k1 : k0, j == 10 * cpb + 1);
            check($sformatf("%s ready c%0d", tag, j), sel ? r1 : r0, j == 10 * cpb + 1);
        end
    endtask

    initial begin
        v0 = 1'b1; v1 = 1'b1; d0 = 8'hA5; d1 = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("rst line %0d", i),  s0, 1'b1);
            check($sformatf("rst ready %0d", i), r0, 1'b1);
            check($sformatf("rst busy %0d", i),  b0, 1'b0);
            check($sformatf("rst done %0d", i),  k0, 1'b0);
            check($sformatf("rst min line %0d", i), s1, 1'b1);
        end
        v0 = 1'b0; v1 = 1'b0;
        clearb = 1'b1;
        @(negedge clock);
        check("post-rst ready", r0, 1'b1);
        check("post-rst busy", b0, 1'b0);

        accept("a5", 1'b0, 8'hA5, 1'b0);
        expect_frame("a5", 1'b0, 8'hA5, 4);

        accept("b2b0", 1'b0, 8'h00, 1'b1);
        d0 = 8'hFF;
        expect_frame("b2b0", 1'b0, 8'h00, 4);
        @(posedge clock);
        #1 v0 = 1'b0;
        expect_frame("b2b1", 1'b0, 8'hFF, 4);

        accept("ign", 1'b0, 8'hA5, 1'b0);
        fork
            expect_frame("ign", 1'b0, 8'hA5, 4);
            begin
                repeat (15) @(negedge clock);
                #1 d0 = 8'h3C; v0 = 1'b1;
                repeat (4) @(negedge clock);
                #1 v0 = 1'b0;
            end
        join
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check($sformatf("ign idle line %0d", i), s0, 1'b1);
            check($sformatf("ign idle busy %0d", i), b0, 1'b0);
        end

        accept("mid", 1'b0, 8'hA5, 1'b0);
        repeat (18) @(negedge clock);
        check("mid bit3 line", s0, 1'b0);
        #2 clearb = 1'b0;
        #1;
        check("mid async line", s0, 1'b1);
        check("mid async busy", b0, 1'b0);
        check("mid async ready", r0, 1'b1);
        check("mid async done", k0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("mid hold done %0d", i), k0, 1'b0);
            check($sformatf("mid hold line %0d", i), s0, 1'b1);
        end
        clearb = 1'b1;
        accept("r81", 1'b0, 8'h81, 1'b0);
        expect_frame("r81", 1'b0, 8'h81, 4);

        accept("min5a", 1'b1, 8'h5A, 1'b0);
        expect_frame("min5a", 1'b1, 8'h5A, 1);
        @(negedge clock);
        check("min idle done", k1, 1'b0);
        check("min idle line", s1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
